// File: rtl/wm_cycle_ctrl.sv
// Washing-machine cycle controller.
// Runs a fixed FILL -> WASH -> DRAIN -> RINSE -> SPIN -> DONE sequence,
// timing each phase in units of TICK_DIV clock cycles. Durations for
// WASH/RINSE/SPIN are latched from BCD presets when the cycle starts.
module wm_cycle_ctrl #(
    parameter int TICK_DIV = 100000000,
    parameter int FILL_T   = 4,
    parameter int DRAIN_T  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic [3:0] t_wash,
    input  logic [3:0] t_rinse,
    input  logic [3:0] t_spin,
    output logic [2:0] phase,
    output logic [3:0] remaining,
    output logic       valve_in,
    output logic       valve_out,
    output logic [1:0] motor,
    output logic       busy,
    output logic       done
);

    localparam int             PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_MAX  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]  PRESC_ZERO = PW'(0);
    localparam logic [PW-1:0]  PRESC_ONE  = PW'(1);
    localparam logic [3:0]     FILL_LEN   = 4'(FILL_T);
    localparam logic [3:0]     DRAIN_LEN  = 4'(DRAIN_T);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_WASH  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_RINSE = 3'd4,
        ST_SPIN  = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    // BCD digits above 9 are treated as 9.
    function automatic logic [3:0] clamp_bcd(input logic [3:0] v);
        if (v > 4'd9) begin
            clamp_bcd = 4'd9;
        end else begin
            clamp_bcd = v;
        end
    endfunction

    state_t         state_r, state_nxt_s, adv_state_s;
    logic [3:0]     remaining_r, remaining_nxt_s, adv_len_s;
    logic [PW-1:0]  presc_r, presc_nxt_s;
    logic [3:0]     lat_wash_r, lat_rinse_r, lat_spin_r;
    logic [3:0]     lat_wash_nxt_s, lat_rinse_nxt_s, lat_spin_nxt_s;
    logic [3:0]     wash_c_s, rinse_c_s, spin_c_s;
    logic           start_q_r, armed_r;
    logic           start_edge_s, busy_s;

    // armed_r blocks the first edge after reset, so a button held through
    // reset release is not mistaken for a fresh press.
    assign start_edge_s = start & ~start_q_r & armed_r;
    assign wash_c_s     = clamp_bcd(t_wash);
    assign rinse_c_s    = clamp_bcd(t_rinse);
    assign spin_c_s     = clamp_bcd(t_spin);
    assign busy_s       = (state_r == ST_FILL)  || (state_r == ST_WASH) ||
                          (state_r == ST_DRAIN) || (state_r == ST_RINSE) ||
                          (state_r == ST_SPIN);

    // State, timer and latched-duration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            remaining_r <= 4'd0;
            presc_r     <= PRESC_ZERO;
            lat_wash_r  <= 4'd0;
            lat_rinse_r <= 4'd0;
            lat_spin_r  <= 4'd0;
            start_q_r   <= 1'b0;
            armed_r     <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            remaining_r <= remaining_nxt_s;
            presc_r     <= presc_nxt_s;
            lat_wash_r  <= lat_wash_nxt_s;
            lat_rinse_r <= lat_rinse_nxt_s;
            lat_spin_r  <= lat_spin_nxt_s;
            start_q_r   <= start;
            armed_r     <= 1'b1;
        end
    end

    // Successor phase and its length when the current timed phase ends.
    always_comb begin
        adv_state_s = ST_IDLE;
        adv_len_s   = 4'd0;
        case (state_r)
            ST_FILL:  begin adv_state_s = ST_WASH;  adv_len_s = lat_wash_r;  end
            ST_WASH:  begin adv_state_s = ST_DRAIN; adv_len_s = DRAIN_LEN;   end
            ST_DRAIN: begin adv_state_s = ST_RINSE; adv_len_s = lat_rinse_r; end
            ST_RINSE: begin adv_state_s = ST_SPIN;  adv_len_s = lat_spin_r;  end
            ST_SPIN:  begin adv_state_s = ST_DONE;  adv_len_s = 4'd0;        end
            default:  begin adv_state_s = ST_IDLE;  adv_len_s = 4'd0;        end
        endcase
    end

    // Next-state logic: stop first, then start/pause/tick handling per state.
    always_comb begin
        state_nxt_s     = state_r;
        remaining_nxt_s = remaining_r;
        presc_nxt_s     = presc_r;
        lat_wash_nxt_s  = lat_wash_r;
        lat_rinse_nxt_s = lat_rinse_r;
        lat_spin_nxt_s  = lat_spin_r;
        if (stop) begin
            state_nxt_s     = ST_IDLE;
            remaining_nxt_s = 4'd0;
            presc_nxt_s     = PRESC_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    remaining_nxt_s = 4'd0;
                    presc_nxt_s     = PRESC_ZERO;
                    if (start_edge_s && ((wash_c_s | rinse_c_s | spin_c_s) != 4'd0)) begin
                        lat_wash_nxt_s  = wash_c_s;
                        lat_rinse_nxt_s = rinse_c_s;
                        lat_spin_nxt_s  = spin_c_s;
                        state_nxt_s     = ST_FILL;
                        remaining_nxt_s = FILL_LEN;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_FILL, ST_WASH, ST_DRAIN, ST_RINSE, ST_SPIN: begin
                    if (pause) begin
                        state_nxt_s = state_r;
                    end else if (remaining_r == 4'd0) begin
                        // zero-length phase: single-cycle dwell
                        state_nxt_s     = adv_state_s;
                        remaining_nxt_s = adv_len_s;
                        presc_nxt_s     = PRESC_ZERO;
                    end else if (presc_r == PRESC_MAX) begin
                        presc_nxt_s = PRESC_ZERO;
                        if (remaining_r == 4'd1) begin
                            state_nxt_s     = adv_state_s;
                            remaining_nxt_s = adv_len_s;
                        end else begin
                            remaining_nxt_s = remaining_r - 4'd1;
                        end
                    end else begin
                        presc_nxt_s = presc_r + PRESC_ONE;
                    end
                end
                ST_DONE: begin
                    remaining_nxt_s = 4'd0;
                    presc_nxt_s     = PRESC_ZERO;
                    if (start_edge_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end
                default: begin
                    state_nxt_s     = ST_IDLE;
                    remaining_nxt_s = 4'd0;
                    presc_nxt_s     = PRESC_ZERO;
                end
            endcase
        end
    end

    // Actuator decode from the registered state; pause silences actuators.
    always_comb begin
        valve_in  = 1'b0;
        valve_out = 1'b0;
        motor     = 2'b00;
        if (!pause) begin
            case (state_r)
                ST_FILL:  valve_in  = 1'b1;
                ST_WASH:  motor     = 2'b01;
                ST_DRAIN: valve_out = 1'b1;
                ST_RINSE: motor     = 2'b01;
                ST_SPIN:  begin valve_out = 1'b1; motor = 2'b10; end
                default:  motor     = 2'b00;
            endcase
        end else begin
            motor = 2'b00;
        end
    end

    assign phase     = state_r;
    assign remaining = remaining_r;
    assign busy      = busy_s;
    assign done      = (state_r == ST_DONE);

endmodule

// File: tb/tb_wm_cycle_ctrl.sv
// Directed bench for wm_cycle_ctrl with TICK_DIV=4, FILL_T=2, DRAIN_T=1.
module tb_wm_cycle_ctrl;

    logic       clk, rst_n, start, stop, pause;
    logic [3:0] t_wash, t_rinse, t_spin;
    logic [2:0] phase;
    logic [3:0] remaining;
    logic       valve_in, valve_out, busy, done;
    logic [1:0] motor;

    int checks   = 0;
    int failures = 0;
    int cyc;

    wm_cycle_ctrl #(.TICK_DIV(4), .FILL_T(2), .DRAIN_T(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
        .t_wash(t_wash), .t_rinse(t_rinse), .t_spin(t_spin),
        .phase(phase), .remaining(remaining), .valve_in(valve_in),
        .valve_out(valve_out), .motor(motor), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Count cycles spent in phase ph, starting just after its entry edge.
    task automatic measure(input logic [2:0] ph, output int n);
        n = 0;
        while (phase == ph && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic press();
        start = 1'b1;
        tick_n(1);
        start = 1'b0;
    endtask

    task automatic presets(input logic [3:0] w, input logic [3:0] r, input logic [3:0] s);
        t_wash = w; t_rinse = r; t_spin = s;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
        presets(4'd0, 4'd0, 4'd0);
        #2;
        check_eq("reset_phase", phase, 0);
        check_eq("reset_outs", {remaining, valve_in, valve_out, motor, busy, done}, 0);
        #20 rst_n = 1'b1;
        tick_n(2);

        // Full cycle 3/2/1
        presets(4'd3, 4'd2, 4'd1);
        press();
        check_eq("t1_fill_phase", phase, 1);
        check_eq("t1_fill_outs", {valve_in, busy, remaining}, {1'b1, 1'b1, 4'd2});
        measure(3'd1, cyc); check_eq("t1_fill_len", cyc, 8);
        check_eq("t1_wash_rem3", remaining, 3);
        check_eq("t1_wash_motor", motor, 1);
        tick_n(4); check_eq("t1_wash_rem2", remaining, 2);
        tick_n(4); check_eq("t1_wash_rem1", remaining, 1);
        tick_n(4); check_eq("t1_drain_phase", phase, 3);
        check_eq("t1_drain_vout", valve_out, 1);
        measure(3'd3, cyc); check_eq("t1_drain_len", cyc, 4);
        check_eq("t1_rinse_motor", motor, 1);
        measure(3'd4, cyc); check_eq("t1_rinse_len", cyc, 8);
        check_eq("t1_spin_outs", {motor, valve_out}, {2'b10, 1'b1});
        measure(3'd5, cyc); check_eq("t1_spin_len", cyc, 4);
        check_eq("t1_done", {phase, done, busy, remaining}, {3'd6, 1'b1, 1'b0, 4'd0});
        press();
        check_eq("t1_done_start_idle", phase, 0);
        tick_n(2);
        check_eq("t1_no_refill", phase, 0);

        // Zero-length WASH/RINSE
        presets(4'd0, 4'd0, 4'd2);
        press();
        measure(3'd1, cyc); check_eq("t2_fill_len", cyc, 8);
        check_eq("t2_wash_rem_motor", {remaining, motor}, {4'd0, 2'b01});
        measure(3'd2, cyc); check_eq("t2_wash_len", cyc, 1);
        measure(3'd3, cyc); check_eq("t2_drain_len", cyc, 4);
        check_eq("t2_rinse_rem_motor", {remaining, motor}, {4'd0, 2'b01});
        measure(3'd4, cyc); check_eq("t2_rinse_len", cyc, 1);
        measure(3'd5, cyc); check_eq("t2_spin_len", cyc, 8);
        check_eq("t2_done", phase, 6);
        stop = 1'b1; tick_n(1);
        check_eq("t2_stop_idle", phase, 0);
        stop = 1'b0;
        presets(4'd0, 4'd0, 4'd0);
        press(); tick_n(1);
        check_eq("t2_zero_ignored", phase, 0);

        // Pause mid-WASH, preset change mid-cycle, stop in RINSE
        presets(4'd3, 4'd2, 4'd1);
        press();
        measure(3'd1, cyc); check_eq("t3_fill_len", cyc, 8);
        t_wash = 4'd9;
        tick_n(6);
        pause = 1'b1; #1;
        check_eq("t3_pause_outs", {valve_in, valve_out, motor, busy}, {4'b0000, 1'b1});
        check_eq("t3_pause_rem", remaining, 2);
        tick_n(5);
        check_eq("t3_pause_frozen", {phase, remaining}, {3'd2, 4'd2});
        pause = 1'b0; #1;
        check_eq("t3_resume_motor", motor, 1);
        measure(3'd2, cyc); check_eq("t3_wash_rest", cyc, 6);
        measure(3'd3, cyc); check_eq("t3_drain_len", cyc, 4);
        tick_n(3);
        stop = 1'b1; start = 1'b1;
        tick_n(1);
        check_eq("t3_stop_idle", phase, 0);
        check_eq("t3_stop_outs", {remaining, valve_in, valve_out, motor, busy, done}, 0);
        stop = 1'b0; start = 1'b0;
        tick_n(2);
        check_eq("t3_stays_idle", phase, 0);

        // Async reset mid-SPIN with start held through release
        presets(4'd1, 4'd1, 4'd2);
        press();
        measure(3'd1, cyc);
        measure(3'd2, cyc);
        measure(3'd3, cyc);
        measure(3'd4, cyc);
        check_eq("t4_in_spin", phase, 5);
        tick_n(2);
        start = 1'b1; rst_n = 1'b0; #1;
        check_eq("t4_async_reset", {phase, remaining, valve_in, valve_out, motor, busy, done}, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick_n(3);
        check_eq("t4_held_start_idle", phase, 0);
        start = 1'b0; tick_n(1);
        check_eq("t4_released_idle", phase, 0);
        press();
        check_eq("t4_new_press_fill", phase, 1);
        stop = 1'b1; tick_n(1); stop = 1'b0;

        // Preset 12 clamped to 9
        presets(4'd12, 4'd1, 4'd1);
        press();
        measure(3'd1, cyc);
        check_eq("t5_wash_rem9", remaining, 9);
        measure(3'd2, cyc); check_eq("t5_wash_len", cyc, 36);
        stop = 1'b1; tick_n(1); stop = 1'b0;
        check_eq("t5_stop_idle", phase, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
